demux1to16_deser: RTL

DEMUX1TO16_DESER -- requirements
Module: demux1to16_deser

---
 rtl/demux1to16_deser_pkg.sv | 12 +
 rtl/demux1to16_deser.sv | 103 ++++++++++
 2 files changed

// File: rtl/demux1to16_deser_pkg.sv
// Shared definitions for the 1-to-N serial demultiplexer / deserializer.
// Holds the default word width and the collector state encoding.
package demux_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/demux1to16_deser.sv
// Serial-to-parallel collector: each accepted bit lands at position sel of a
// shadow word; once every position is written the word is presented on out.
module demux1to16_deser
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic [SEL_W-1:0] sel,
   input  logic             flush,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W:0]   fill_cnt,
   output logic             dup_err
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // Input side: in_ready depends only on state. Output side: out/out_valid
   // stay frozen while out_valid && !out_ready.

   localparam logic [SEL_W:0] LAST_CNT = (SEL_W+1)'(WIDTH - 1);
   localparam logic [SEL_W:0] FULL_CNT = (SEL_W+1)'(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] shadow;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] shadow_nxt;
   logic             accept;
   logic             is_new;
   logic             complete;
   logic             out_hs;

   assign in_ready = (state == COLLECT);
   assign accept   = in_valid && in_ready && !flush;
   assign is_new   = !mask[sel];
   assign complete = accept && is_new && (fill_cnt == LAST_CNT);
   assign out_hs   = out_valid && out_ready;

   // Shadow with the incoming bit merged, so the completing bit reaches out.
   always_comb begin
      shadow_nxt      = shadow;
      shadow_nxt[sel] = in_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
      end else if (accept) begin
         shadow <= shadow_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask <= '0;
      end else if (flush || out_hs) begin
         mask <= '0;
      end else if (accept) begin
         mask[sel] <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt <= '0;
      end else if (flush || out_hs) begin
         fill_cnt <= '0;
      end else if (accept && is_new && fill_cnt != FULL_CNT) begin
         fill_cnt <= fill_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dup_err <= 1'b0;
      end else begin
         dup_err <= accept && !is_new;
      end
   end

   // out keeps the last delivered word after handshake or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         out_valid <= 1'b0;
         out       <= '0;
      end else if (flush || out_hs) begin
         state     <= COLLECT;
         out_valid <= 1'b0;
      end else if (complete) begin
         state     <= HOLD;
         out_valid <= 1'b1;
         out       <= shadow_nxt;
      end
   end

endmodule
